key_led_ctrl: RTL

//   Controller for the board's key-to-LED path. Two raw push-buttons are synchronised and

---
 rtl/key_led_ctrl_pkg.sv | 31 +++
 rtl/key_led_ctrl_debounce.sv | 62 ++++++
 rtl/key_led_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/key_led_ctrl_pkg.sv
// Shared mode encodings and helpers
// for the key-to-LED controller.
`timescale 1ns/1ps
package key_led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_e;

  // Counter width able to hold 0..n-1, never zero bits.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Mode advance order on a key1 press.
  function automatic mode_e mode_adv(input mode_e m);
    mode_e r;
    r = MODE_OFF;
    case (m)
      MODE_OFF:  r = MODE_ON;
      MODE_ON:   r = MODE_SLOW;
      MODE_SLOW: r = MODE_FAST;
      default:   r = MODE_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_led_ctrl_debounce.sv
// Key synchroniser, debouncer and
// falling-edge press pulse generator.
`timescale 1ns/1ps
module key_debounce
  import key_led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_stable,
  output logic key_press
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYC - 1);

  logic          s1;
  logic          s2;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser, idles released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after it persists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      key_stable <= 1'b1;
    end else if (s2 == key_stable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt        <= '0;
      key_stable <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // One pulse per accepted 1->0 transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d  <= 1'b1;
      key_press <= 1'b0;
    end else begin
      stable_d  <= key_stable;
      key_press <= stable_d & ~key_stable;
    end
  end

endmodule

// File: rtl/key_led_ctrl.sv
// Key-driven LED mode controller:
// debounced presses step OFF/ON/SLOW/FAST.
`timescale 1ns/1ps
module key_led_ctrl
  import key_led_ctrl_pkg::*;
#(
  parameter int   DEBOUNCE_CYC   = 1_000_000,
  parameter int   BLINK_SLOW_CYC = 25_000_000,
  parameter int   BLINK_FAST_CYC = 5_000_000,
  parameter logic LED_ON_LVL     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key1,
  input  logic       key2,
  output logic       led,
  output logic [1:0] mode,
  output logic       key1_press,
  output logic       key2_press
);

  localparam int BMAX =
    (BLINK_SLOW_CYC > BLINK_FAST_CYC) ?
    BLINK_SLOW_CYC : BLINK_FAST_CYC;
  localparam int BW = cnt_width(BMAX);
  localparam logic [BW-1:0] SLOW_LAST =
    BW'(BLINK_SLOW_CYC - 1);
  localparam logic [BW-1:0] FAST_LAST =
    BW'(BLINK_FAST_CYC - 1);

  mode_e         state;
  mode_e         nxt;
  logic [BW-1:0] bcnt;
  logic [BW-1:0] half_last;
  logic          phase;
  logic          blinking;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key1),
    .key_stable(),
    .key_press (key1_press)
  );

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key2),
    .key_stable(),
    .key_press (key2_press)
  );

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MODE_OFF;
    else        state <= nxt;
  end

  // Next mode: key2 forces OFF, key1 advances.
  always_comb begin
    nxt = state;
    if (key2_press)      nxt = MODE_OFF;
    else if (key1_press) nxt = mode_adv(state);
  end

  assign mode     = state;
  assign blinking = (state == MODE_SLOW) ||
                    (state == MODE_FAST);
  assign half_last = (state == MODE_SLOW) ?
                     SLOW_LAST : FAST_LAST;

  // Blink half-period counter; restarts lit on mode change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (nxt != state) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (blinking) begin
      if (bcnt == half_last) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end else begin
      bcnt <= '0;
    end
  end

  // Registered LED drive from mode and phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= ~LED_ON_LVL;
    end else begin
      case (state)
        MODE_OFF: led <= ~LED_ON_LVL;
        MODE_ON:  led <= LED_ON_LVL;
        default:  led <= phase ? LED_ON_LVL
                               : ~LED_ON_LVL;
      endcase
    end
  end

endmodule
